// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one multi-cycle ALU between two requesters.
// Round-robin grant in IDLE, registered operands drive the ALU, a down-counter
// times the fixed ALU latency, and the captured result is returned to the
// port that owns the in-flight operation. Only one operation is ever in flight.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no operation in flight; grant evaluated, request accepted here
// ISSUE | operands registered and on the ALU; wait counter loaded
// WAIT  | counting down the ALU latency; result sampled at count == 1
// RESP  | response valid to the owner until it signals ready

module alu_arbiter #(
    parameter int N   = 2,
    parameter int M   = 8,
    parameter int LAT = 1,
    parameter int CW  = 16
) (
    input  logic          i_clk,
    input  logic          i_reset,

    input  logic          i_req_valid_0,
    input  logic          i_req_valid_1,
    output logic          o_req_ready_0,
    output logic          o_req_ready_1,
    input  logic [N-1:0]  i_req_op_0,
    input  logic [N-1:0]  i_req_op_1,
    input  logic [M-1:0]  i_req_a_0,
    input  logic [M-1:0]  i_req_a_1,
    input  logic [M-1:0]  i_req_b_0,
    input  logic [M-1:0]  i_req_b_1,

    output logic          o_rsp_valid_0,
    output logic          o_rsp_valid_1,
    input  logic          i_rsp_ready_0,
    input  logic          i_rsp_ready_1,
    output logic [M-1:0]  o_rsp_result,
    output logic [3:0]    o_rsp_status,

    output logic [N-1:0]  o_alu_op,
    output logic [M-1:0]  o_alu_a,
    output logic [M-1:0]  o_alu_b,
    input  logic [M-1:0]  i_alu_result,
    input  logic [3:0]    i_alu_status,

    output logic          o_busy,
    output logic [CW-1:0] o_issue_cnt
);

    // Counter just wide enough to hold LAT.
    localparam int WW = (LAT < 2) ? 1 : $clog2(LAT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic           last_grant;
    logic           owner;
    logic           gnt_vld;
    logic           gnt_port;
    logic           owner_ready;
    logic           wait_tc;
    logic [WW-1:0]  wait_cnt;

    // Round-robin grant, only meaningful while IDLE; ties go to the port
    // that did not win last time.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_port = 1'b0;
        if (state == IDLE) begin
            if (i_req_valid_0 && i_req_valid_1) begin
                gnt_vld  = 1'b1;
                gnt_port = ~last_grant;
            end else if (i_req_valid_0) begin
                gnt_vld  = 1'b1;
                gnt_port = 1'b0;
            end else if (i_req_valid_1) begin
                gnt_vld  = 1'b1;
                gnt_port = 1'b1;
            end
        end
    end

    assign o_req_ready_0 = gnt_vld && !gnt_port;
    assign o_req_ready_1 = gnt_vld &&  gnt_port;

    // The non-owner's response ready has no effect.
    assign owner_ready = owner ? i_rsp_ready_1 : i_rsp_ready_0;
    assign wait_tc     = (wait_cnt == WW'(1));

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (gnt_vld)     state_nxt = ISSUE;
            ISSUE:                    state_nxt = WAIT;
            WAIT:    if (wait_tc)     state_nxt = RESP;
            RESP:    if (owner_ready) state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // Accept path: latch the winner's request onto the ALU inputs, record
    // the owner and count the issue. Held untouched until the next accept.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_alu_op    <= '0;
            o_alu_a     <= '0;
            o_alu_b     <= '0;
            owner       <= 1'b0;
            o_issue_cnt <= '0;
        end else if (gnt_vld) begin
            o_alu_op    <= gnt_port ? i_req_op_1 : i_req_op_0;
            o_alu_a     <= gnt_port ? i_req_a_1  : i_req_a_0;
            o_alu_b     <= gnt_port ? i_req_b_1  : i_req_b_0;
            owner       <= gnt_port;
            o_issue_cnt <= o_issue_cnt + CW'(1);
        end
    end

    // Latency down-counter: loaded in ISSUE, decremented through WAIT.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            wait_cnt <= '0;
        end else if (state == ISSUE) begin
            wait_cnt <= WW'(LAT);
        end else if (state == WAIT) begin
            wait_cnt <= wait_cnt - WW'(1);
        end
    end

    // Capture the ALU output on the terminal count; held through RESP.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_rsp_result <= '0;
            o_rsp_status <= '0;
        end else if (state == WAIT && wait_tc) begin
            o_rsp_result <= i_alu_result;
            o_rsp_status <= i_alu_status;
        end
    end

    // Fairness memory: the owner of a completed response loses the next tie.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            last_grant <= 1'b1;
        end else if (state == RESP && owner_ready) begin
            last_grant <= owner;
        end
    end

    assign o_rsp_valid_0 = (state == RESP) && !owner;
    assign o_rsp_valid_1 = (state == RESP) &&  owner;
    assign o_busy        = (state != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: two arbiter instances (LAT=1/CW=16 and LAT=3/CW=4) driven by
// random and directed transactions, checked against a transaction-level model
// of round-robin order, issue count, response timing and ALU arithmetic.
// The emulated ALU only returns the true result once its inputs have been
// stable for LAT cycles, so sampling at the wrong cycle yields a wrong value.

module tb_alu_arbiter;

    logic i_clk   = 1'b0;
    logic i_reset = 1'b1;

    // Clock generation.
    always #5 i_clk = ~i_clk;

    logic [1:0]  req_valid  [2];
    logic [1:0]  req_op     [2][2];
    logic [7:0]  req_a      [2][2];
    logic [7:0]  req_b      [2][2];
    logic [1:0]  rsp_ready  [2];

    logic [1:0]  req_ready  [2];
    logic [1:0]  rsp_valid  [2];
    logic [7:0]  rsp_result [2];
    logic [3:0]  rsp_status [2];
    logic [1:0]  alu_op     [2];
    logic [7:0]  alu_a      [2];
    logic [7:0]  alu_b      [2];
    logic        busy       [2];
    logic [15:0] issue_cnt  [2];

    int n_chk  = 0;
    int n_fail = 0;
    int last_m [2];
    int cnt_m  [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LATG = (g == 0) ? 1 : 3;
        localparam int CWG  = (g == 0) ? 16 : 4;

        logic            rdy0, rdy1, vld0, vld1, bsy;
        logic [7:0]      res, aa, bb, alu_res, true_res;
        logic [3:0]      st, alu_st;
        logic [1:0]      op;
        logic [CWG-1:0]  cnt;
        logic [17:0]     snap;
        int              age = 0;

        alu_arbiter #(.N(2), .M(8), .LAT(LATG), .CW(CWG)) u_dut (
            .i_clk         (i_clk),
            .i_reset       (i_reset),
            .i_req_valid_0 (req_valid[g][0]),
            .i_req_valid_1 (req_valid[g][1]),
            .o_req_ready_0 (rdy0),
            .o_req_ready_1 (rdy1),
            .i_req_op_0    (req_op[g][0]),
            .i_req_op_1    (req_op[g][1]),
            .i_req_a_0     (req_a[g][0]),
            .i_req_a_1     (req_a[g][1]),
            .i_req_b_0     (req_b[g][0]),
            .i_req_b_1     (req_b[g][1]),
            .o_rsp_valid_0 (vld0),
            .o_rsp_valid_1 (vld1),
            .i_rsp_ready_0 (rsp_ready[g][0]),
            .i_rsp_ready_1 (rsp_ready[g][1]),
            .o_rsp_result  (res),
            .o_rsp_status  (st),
            .o_alu_op      (op),
            .o_alu_a       (aa),
            .o_alu_b       (bb),
            .i_alu_result  (alu_res),
            .i_alu_status  (alu_st),
            .o_busy        (bsy),
            .o_issue_cnt   (cnt)
        );

        // ALU emulation: count cycles the inputs have been stable.
        always @(negedge i_clk) begin
            if ({op, aa, bb} !== snap) begin
                snap <= {op, aa, bb};
                age  <= 0;
            end else if (age < 1000) begin
                age <= age + 1;
            end
        end

        assign true_res = 8'(int'(aa) - 2 * int'(bb));
        assign alu_res  = (age >= LATG) ? true_res : (true_res ^ 8'hA5);
        assign alu_st   = (age >= LATG) ? {3'b000, aa < bb} : {3'b111, ~(aa < bb)};

        assign req_ready[g]  = {rdy1, rdy0};
        assign rsp_valid[g]  = {vld1, vld0};
        assign rsp_result[g] = res;
        assign rsp_status[g] = st;
        assign alu_op[g]     = op;
        assign alu_a[g]      = aa;
        assign alu_b[g]      = bb;
        assign busy[g]       = bsy;
        assign issue_cnt[g]  = 16'(cnt);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at time %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_zero(input int k, input string tag);
        check({tag, "_rsp_valid"}, rsp_valid[k], 0);
        check({tag, "_busy"},      busy[k], 0);
        check({tag, "_alu"},       {alu_op[k], alu_a[k], alu_b[k]}, 0);
        check({tag, "_result"},    rsp_result[k], 0);
        check({tag, "_status"},    rsp_status[k], 0);
        check({tag, "_issue_cnt"}, issue_cnt[k], 0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            last_m[k] = 1;
            cnt_m[k]  = 0;
        end
    endtask

    task automatic do_reset();
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 2'b00;
            rsp_ready[k] = 2'b00;
        end
        i_reset = 1'b1;
        @(negedge i_clk);
        for (int k = 0; k < 2; k++) begin
            check_zero(k, "reset");
            check("reset_req_ready", req_ready[k], 0);
        end
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        model_reset();
        @(posedge i_clk); #1;
    endtask

    // One full transaction on instance k, entered and left in the input phase
    // (just after a rising edge) with the instance idle.
    task automatic do_txn(input int k, input bit v0, input bit v1,
                          input logic [1:0] op0, input logic [7:0] a0, input logic [7:0] b0,
                          input logic [1:0] op1, input logic [7:0] a1, input logic [7:0] b1,
                          input int hold, output int gnt,
                          output logic [7:0] got_res, output logic [3:0] got_st);
        int         w;
        int         lat;
        int         cmask;
        logic [1:0] emask;
        logic [1:0] eop;
        logic [7:0] ea, eb, eres;
        logic [3:0] est;

        lat   = (k == 0) ? 1 : 3;
        cmask = (k == 0) ? 32'hFFFF : 32'hF;
        req_op[k][0] = op0; req_a[k][0] = a0; req_b[k][0] = b0;
        req_op[k][1] = op1; req_a[k][1] = a1; req_b[k][1] = b1;
        req_valid[k] = {v1, v0};
        rsp_ready[k] = 2'b00;

        if (v0 && v1)  w = 1 - last_m[k];
        else if (v0)   w = 0;
        else           w = 1;
        emask = (w == 0) ? 2'b01 : 2'b10;
        eop   = (w == 0) ? op0 : op1;
        ea    = (w == 0) ? a0 : a1;
        eb    = (w == 0) ? b0 : b1;
        eres  = 8'(int'(ea) - 2 * int'(eb));
        est   = (ea < eb) ? 4'd1 : 4'd0;

        @(negedge i_clk);
        check("req_ready_grant", req_ready[k], emask);
        check("busy_idle", busy[k], 0);
        gnt = req_ready[k][1] ? 1 : 0;
        @(posedge i_clk); #1;
        cnt_m[k]++;

        // The winner keeps requesting with a new payload; it must not leak in.
        req_op[k][w] = 2'($urandom);
        req_a[k][w]  = 8'($urandom);
        req_b[k][w]  = 8'($urandom);

        for (int j = 0; j < lat + 1; j++) begin
            @(negedge i_clk);
            check("rsp_early", rsp_valid[k], 0);
            check("ready_in_flight", req_ready[k], 0);
            check("busy_in_flight", busy[k], 1);
            check("alu_inputs", {alu_op[k], alu_a[k], alu_b[k]}, {eop, ea, eb});
            @(posedge i_clk); #1;
        end

        got_res = '0;
        got_st  = '0;
        for (int j = 0; j <= hold; j++) begin
            rsp_ready[k] = (j == hold) ? emask : ~emask;
            @(negedge i_clk);
            check("rsp_valid", rsp_valid[k], emask);
            check("rsp_result", rsp_result[k], eres);
            check("rsp_status", rsp_status[k], est);
            check("ready_in_resp", req_ready[k], 0);
            check("alu_hold", {alu_op[k], alu_a[k], alu_b[k]}, {eop, ea, eb});
            check("issue_cnt", issue_cnt[k], cnt_m[k] & cmask);
            if (j == 0) begin
                got_res = rsp_result[k];
                got_st  = rsp_status[k];
            end
            @(posedge i_clk); #1;
        end
        last_m[k]    = w;
        rsp_ready[k] = 2'b00;
        req_valid[k] = 2'b00;

        @(negedge i_clk);
        check("rsp_drop", rsp_valid[k], 0);
        check("busy_drop", busy[k], 0);
        @(posedge i_clk); #1;
    endtask

    task automatic rand_txn(input int k, input int max_hold);
        logic [1:0] pat;
        int         gnt;
        logic [7:0] r;
        logic [3:0] s;
        pat = 2'($urandom_range(1, 3));
        do_txn(k, pat[0], pat[1],
               2'($urandom), 8'($urandom), 8'($urandom),
               2'($urandom), 8'($urandom), 8'($urandom),
               int'($urandom_range(0, max_hold)), gnt, r, s);
    endtask

    // Hard stop in case anything stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        int         gnt;
        logic [7:0] r;
        logic [3:0] s;
        int         exp_seq [4] = '{0, 1, 0, 1};

        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 2'b00;
            rsp_ready[k] = 2'b00;
            for (int p = 0; p < 2; p++) begin
                req_op[k][p] = 2'b00;
                req_a[k][p]  = 8'h00;
                req_b[k][p]  = 8'h00;
            end
        end
        model_reset();
        do_reset();

        // Single request, LAT=1: 20 - 2*3 = 14.
        do_txn(0, 1'b1, 1'b0, 2'd0, 8'd20, 8'd3, 2'd1, 8'd99, 8'd1, 0, gnt, r, s);
        check("single_grant", gnt, 0);
        check("single_result", r, 8'd14);
        check("single_status", s, 4'b0000);

        // Contention from reset: 0, 1, 0, 1.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            do_txn(0, 1'b1, 1'b1,
                   2'($urandom), 8'($urandom), 8'($urandom),
                   2'($urandom), 8'($urandom), 8'($urandom),
                   0, gnt, r, s);
            check("contention_order", gnt, exp_seq[i]);
        end

        // Backpressure on port 1 for 10 cycles with port 0 requesting.
        do_txn(0, 1'b1, 1'b1, 2'd1, 8'd9, 8'd2, 2'd2, 8'd3, 8'd4, 0, gnt, r, s);
        check("bp_first_grant", gnt, 0);
        do_txn(0, 1'b1, 1'b1, 2'd3, 8'd77, 8'd1, 2'd2, 8'd200, 8'd60, 10, gnt, r, s);
        check("bp_grant", gnt, 1);
        check("bp_result", r, 8'd80);

        // LAT=3: 5 - 14 = -9 = 0xF7, a < b.
        do_txn(1, 1'b1, 1'b0, 2'd2, 8'd5, 8'd7, 2'd0, 8'd0, 8'd0, 2, gnt, r, s);
        check("lat3_result", r, 8'hF7);
        check("lat3_status", s, 4'b0001);

        // Async reset while the LAT=3 instance is in WAIT.
        req_op[1][0] = 2'd2; req_a[1][0] = 8'h40; req_b[1][0] = 8'h10;
        req_valid[1] = 2'b01;
        rsp_ready[1] = 2'b00;
        @(posedge i_clk); #1;
        req_valid[1] = 2'b00;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        check("wait_busy", busy[1], 1);
        check("wait_alu_a", alu_a[1], 8'h40);
        #1;
        i_reset = 1'b1;
        #1;
        check_zero(1, "async_reset");
        check("async_reset_ready", req_ready[1], 0);
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        model_reset();
        for (int j = 0; j < 8; j++) begin
            @(negedge i_clk);
            check("no_rsp_after_reset", rsp_valid[1], 0);
            check("idle_after_reset", busy[1], 0);
            @(posedge i_clk); #1;
        end

        // Random traffic on the LAT=1 instance.
        for (int i = 0; i < 20; i++) rand_txn(0, 3);

        // Counter wrap, CW=4: 17 accepts leaves the counter at 1.
        for (int i = 0; i < 17; i++) rand_txn(1, 2);
        check("wrap_cnt", issue_cnt[1], 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
